matrix_scan_ctrl: RTL and testbench

MATRIX_SCAN_CTRL -- requirements
Module: matrix_scan_ctrl

---
 rtl/matrix_pkg.sv | 20 ++
 rtl/matrix_scan_ctrl_if.sv | 27 ++
 rtl/matrix_bank_store.sv | 49 ++++
 rtl/matrix_tick_gen.sv | 52 +++++
 rtl/matrix_scan_ctrl.sv | 111 +++++++++++
 tb/tb_matrix_scan_ctrl.sv | 174 +++++++++++++++++
 6 files changed

// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared sizes, scan FSM states and row-select helper
package matrix_pkg;

  localparam int ROWS   = 8;
  localparam int COLS   = 8;
  localparam int TICKS  = 8;
  localparam int ROW_W  = $clog2(ROWS);
  localparam int TICK_W = $clog2(TICKS);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

  // Active-low one-hot select for the given row index.
  function automatic logic [ROWS-1:0] row_sel_n(input logic [ROW_W-1:0] row);
    return ~({{(ROWS-1){1'b0}}, 1'b1} << row);
  endfunction

endpackage

// File: rtl/matrix_scan_ctrl_if.sv
// rtl/matrix_scan_ctrl_if.sv - back-bank write and bank-swap handshake bundle
interface matrix_scan_ctrl_if;
  import matrix_pkg::*;

  logic             wr_en;
  logic [ROW_W-1:0] wr_row;
  logic [COLS-1:0]  wr_data;
  logic             swap_req;
  logic             swap_ack;

  modport master (
    output wr_en,
    output wr_row,
    output wr_data,
    output swap_req,
    input  swap_ack
  );

  modport slave (
    input  wr_en,
    input  wr_row,
    input  wr_data,
    input  swap_req,
    output swap_ack
  );

endinterface

// File: rtl/matrix_bank_store.sv
// rtl/matrix_bank_store.sv - double-buffered 8x8 pixel banks with coalescing swap request
module matrix_bank_store
  import matrix_pkg::*;
(
  input  logic                clkI,
  input  logic                rstN,
  input  logic                i_swap_window,
  input  logic [ROW_W-1:0]    i_rd_row,
  output logic [COLS-1:0]     o_rd_data,
  matrix_scan_ctrl_if.slave   bus
);

  logic [COLS-1:0] r_bank [2][ROWS];
  logic            r_bank_sel;
  logic            r_pending;
  logic            r_swap_ack;
  logic            w_back;
  logic            w_swap_do;

  assign w_back    = ~r_bank_sel;
  assign w_swap_do = (r_pending || bus.swap_req) && i_swap_window;

  // Writes target the back bank as seen before any flip in the same cycle.
  always_ff @(posedge clkI or negedge rstN) begin
    if (!rstN) begin
      r_bank_sel <= 1'b0;
      r_pending  <= 1'b0;
      r_swap_ack <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          r_bank[b][r] <= '0;
        end
      end
    end else begin
      r_swap_ack <= w_swap_do;
      r_pending  <= (r_pending || bus.swap_req) && !w_swap_do;
      if (w_swap_do) begin
        r_bank_sel <= ~r_bank_sel;
      end
      if (bus.wr_en) begin
        r_bank[w_back][bus.wr_row] <= bus.wr_data;
      end
    end
  end

  assign o_rd_data    = r_bank[r_bank_sel][i_rd_row];
  assign bus.swap_ack = r_swap_ack;

endmodule

// File: rtl/matrix_tick_gen.sv
// rtl/matrix_tick_gen.sv - pre/tick/row counter chain; holds at zero while not running
module matrix_tick_gen
  import matrix_pkg::*;
#(
  parameter int PRE = 125
) (
  input  logic              clkI,
  input  logic              rstN,
  input  logic              run,
  output logic              pre_last,
  output logic [TICK_W-1:0] tick,
  output logic [ROW_W-1:0]  row,
  output logic              frame_last
);

  localparam int PRE_W = (PRE > 1) ? $clog2(PRE) : 1;

  logic [PRE_W-1:0]  r_pre;
  logic [TICK_W-1:0] r_tick;
  logic [ROW_W-1:0]  r_row;
  logic              w_pre_last;
  logic              w_tick_last;

  assign w_pre_last  = (r_pre == PRE_W'(PRE - 1));
  assign w_tick_last = (r_tick == TICK_W'(TICKS - 1));

  always_ff @(posedge clkI or negedge rstN) begin
    if (!rstN) begin
      r_pre  <= '0;
      r_tick <= '0;
      r_row  <= '0;
    end else if (!run) begin
      r_pre  <= '0;
      r_tick <= '0;
      r_row  <= '0;
    end else if (w_pre_last) begin
      r_pre  <= '0;
      r_tick <= r_tick + TICK_W'(1);
      if (w_tick_last) begin
        r_row <= r_row + ROW_W'(1);
      end
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  assign pre_last   = w_pre_last;
  assign tick       = r_tick;
  assign row        = r_row;
  assign frame_last = w_pre_last && w_tick_last && (r_row == ROW_W'(ROWS - 1));

endmodule

// File: rtl/matrix_scan_ctrl.sv
// rtl/matrix_scan_ctrl.sv - 8x8 LED matrix scanner with PWM brightness and double buffering
module matrix_scan_ctrl
  import matrix_pkg::*;
#(
  parameter int PRE = 125
) (
  input  logic       clkI,
  input  logic       rstN,
  input  logic       enable,
  input  logic [2:0] brightness,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_data,
  input  logic       swap_req,
  output logic       swap_ack,
  output logic       frame_start,
  output logic [7:0] matrix_row,
  output logic [7:0] matrix_col
);

  scan_state_e       r_state;
  scan_state_e       w_state_nxt;
  logic              w_run;
  logic              w_pre_last;
  logic              w_frame_last;
  logic              w_lit;
  logic              w_swap_window;
  logic [TICK_W-1:0] w_tick;
  logic [ROW_W-1:0]  w_row;
  logic [COLS-1:0]   w_front_row;
  logic              r_tick_first;
  logic              r_frame_start;
  logic [ROWS-1:0]   r_matrix_row;
  logic [COLS-1:0]   r_matrix_col;

  matrix_scan_ctrl_if u_bus ();

  assign u_bus.wr_en    = wr_en;
  assign u_bus.wr_row   = wr_row;
  assign u_bus.wr_data  = wr_data;
  assign u_bus.swap_req = swap_req;
  assign swap_ack       = u_bus.swap_ack;

  always_ff @(posedge clkI or negedge rstN) begin
    if (!rstN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (enable)  w_state_nxt = SCAN;
      SCAN:    if (!enable) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Dropping enable blanks from the very next output cycle, not one later.
  assign w_run         = (r_state == SCAN) && enable;
  assign w_lit         = w_run && (w_tick != '0) && (w_tick <= brightness);
  assign w_swap_window = (r_state == IDLE) || ((r_state == SCAN) && w_frame_last);

  matrix_tick_gen #(
    .PRE (PRE)
  ) u_tick_gen (
    .clkI       (clkI),
    .rstN       (rstN),
    .run        (w_run),
    .pre_last   (w_pre_last),
    .tick       (w_tick),
    .row        (w_row),
    .frame_last (w_frame_last)
  );

  matrix_bank_store u_bank_store (
    .clkI          (clkI),
    .rstN          (rstN),
    .i_swap_window (w_swap_window),
    .i_rd_row      (w_row),
    .o_rd_data     (w_front_row),
    .bus           (u_bus.slave)
  );

  // r_tick_first marks the first prescaler cycle of the current tick.
  always_ff @(posedge clkI or negedge rstN) begin
    if (!rstN) begin
      r_tick_first  <= 1'b1;
      r_frame_start <= 1'b0;
      r_matrix_row  <= '1;
      r_matrix_col  <= '1;
    end else begin
      r_tick_first  <= !w_run || w_pre_last;
      r_frame_start <= w_run && r_tick_first && (w_row == '0) && (w_tick == '0);
      if (w_lit) begin
        r_matrix_row <= row_sel_n(w_row);
        r_matrix_col <= ~w_front_row;
      end else begin
        r_matrix_row <= '1;
        r_matrix_col <= '1;
      end
    end
  end

  assign frame_start = r_frame_start;
  assign matrix_row  = r_matrix_row;
  assign matrix_col  = r_matrix_col;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// tb/tb_matrix_scan_ctrl.sv - directed self-checking bench for matrix_scan_ctrl at PRE=2
module tb_matrix_scan_ctrl;

  localparam int PRE = 2;
  localparam logic [63:0] IMG1 = 64'h0000_0000_A500_0000;
  localparam logic [63:0] IMG0 = 64'h0000_8100_0000_3C00;
  localparam logic [63:0] IMG_CLR = 64'h0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [2:0] brightness = 3'd0;
  logic       frame_start;
  logic [7:0] matrix_row;
  logic [7:0] matrix_col;

  int n_vec = 0;
  int n_miss = 0;

  matrix_scan_ctrl_if tb_bus ();

  matrix_scan_ctrl #(
    .PRE (PRE)
  ) dut (
    .clkI        (clk),
    .rstN        (rst_n),
    .enable      (enable),
    .brightness  (brightness),
    .wr_en       (tb_bus.wr_en),
    .wr_row      (tb_bus.wr_row),
    .wr_data     (tb_bus.wr_data),
    .swap_req    (tb_bus.swap_req),
    .swap_ack    (tb_bus.swap_ack),
    .frame_start (frame_start),
    .matrix_row  (matrix_row),
    .matrix_col  (matrix_col)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  // Called at the negedge of a frame_start cycle; returns at the next one.
  task automatic scan_frame(input string tag, input logic [63:0] img, input logic [2:0] bri,
                            input int swap_k, input int wr_k, input logic [2:0] w_row,
                            input logic [7:0] w_data, input logic exp_swap);
    int         lit_cnt [8];
    int         r;
    int         t;
    logic       lit;
    logic [7:0] e_row;
    logic [7:0] e_col;
    for (int i = 0; i < 8; i++) lit_cnt[i] = 0;
    for (int k = 0; k < 128; k++) begin
      r     = k / 16;
      t     = (k / 2) % 8;
      lit   = (t >= 1) && (t <= int'(bri));
      e_row = lit ? ~(8'h01 << r) : 8'hFF;
      e_col = lit ? ~img[r*8 +: 8] : 8'hFF;
      if (matrix_row != 8'hFF) lit_cnt[r]++;
      chk({tag, "_row"}, 32'(matrix_row), 32'(e_row));
      chk({tag, "_col"}, 32'(matrix_col), 32'(e_col));
      chk({tag, "_fs"}, 32'(frame_start), 32'(k == 0));
      chk({tag, "_ack"}, 32'(tb_bus.swap_ack), 32'(exp_swap && (k == 127)));
      tb_bus.swap_req = (swap_k >= 0) && (k == swap_k || k == swap_k + 5 || k == swap_k + 9);
      tb_bus.wr_en    = (k == wr_k);
      tb_bus.wr_row   = w_row;
      tb_bus.wr_data  = w_data;
      @(negedge clk);
    end
    tb_bus.swap_req = 1'b0;
    tb_bus.wr_en    = 1'b0;
    for (int i = 0; i < 8; i++) chk({tag, "_litcnt"}, 32'(lit_cnt[i]), 32'(int'(bri) * PRE));
  endtask

  initial begin
    bit found;
    tb_bus.wr_en    = 1'b0;
    tb_bus.wr_row   = 3'd0;
    tb_bus.wr_data  = 8'h00;
    tb_bus.swap_req = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_row", 32'(matrix_row), 32'hFF);
    chk("rst_col", 32'(matrix_col), 32'hFF);
    chk("rst_ack", 32'(tb_bus.swap_ack), 32'h0);
    chk("rst_fs", 32'(frame_start), 32'h0);

    enable         = 1'b1;
    brightness     = 3'd7;
    tb_bus.wr_en   = 1'b1;
    tb_bus.wr_row  = 3'd3;
    tb_bus.wr_data = 8'hA5;
    rst_n          = 1'b1;
    @(negedge clk);
    chk("en_fs_early", 32'(frame_start), 32'h0);
    tb_bus.wr_en    = 1'b0;
    tb_bus.swap_req = 1'b1;
    @(negedge clk);
    chk("en_fs", 32'(frame_start), 32'h1);
    tb_bus.swap_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (tb_bus.swap_ack) found = 1'b1;
    end
    chk("first_ack_seen", 32'(found), 32'h1);
    @(negedge clk);

    scan_frame("f1_b7", IMG1, 3'd7, -1, 10, 3'd1, 8'h3C, 1'b0);
    brightness = 3'd2;
    scan_frame("f2_b2", IMG1, 3'd2, -1, -1, 3'd0, 8'h00, 1'b0);
    brightness = 3'd0;
    scan_frame("f3_b0", IMG1, 3'd0, -1, -1, 3'd0, 8'h00, 1'b0);
    brightness = 3'd7;
    scan_frame("f4_swap", IMG1, 3'd7, 40, 126, 3'd5, 8'h81, 1'b1);
    scan_frame("f5_new", IMG0, 3'd7, -1, -1, 3'd0, 8'h00, 1'b0);

    chk("f6_fs", 32'(frame_start), 32'h1);
    repeat (66) @(negedge clk);
    chk("row4_row", 32'(matrix_row), 32'hEF);
    chk("row4_col", 32'(matrix_col), 32'hFF);
    enable = 1'b0;
    @(negedge clk);
    chk("dis_row", 32'(matrix_row), 32'hFF);
    chk("dis_col", 32'(matrix_col), 32'hFF);
    @(negedge clk);
    chk("idle_fs", 32'(frame_start), 32'h0);
    chk("idle_row", 32'(matrix_row), 32'hFF);
    tb_bus.swap_req = 1'b1;
    @(negedge clk);
    tb_bus.swap_req = 1'b0;
    chk("idle_ack", 32'(tb_bus.swap_ack), 32'h1);
    @(negedge clk);
    chk("idle_ack_end", 32'(tb_bus.swap_ack), 32'h0);
    enable = 1'b1;
    @(negedge clk);
    chk("re_fs_early", 32'(frame_start), 32'h0);
    @(negedge clk);
    scan_frame("f7_reen", IMG1, 3'd7, -1, -1, 3'd0, 8'h00, 1'b0);

    repeat (52) @(negedge clk);
    chk("pre_rst_row", 32'(matrix_row), 32'hF7);
    chk("pre_rst_col", 32'(matrix_col), 32'h5A);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_row", 32'(matrix_row), 32'hFF);
    chk("arst_col", 32'(matrix_col), 32'hFF);
    chk("arst_fs", 32'(frame_start), 32'h0);
    chk("arst_ack", 32'(tb_bus.swap_ack), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_fs_early", 32'(frame_start), 32'h0);
    @(negedge clk);
    scan_frame("f8_clr", IMG_CLR, 3'd7, -1, -1, 3'd0, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, vectors %0d miscompares %0d", n_vec, n_miss);
    $fatal(1);
  end

endmodule
